// File: rtl/tinyalu_pkg.sv
// Shared definitions for the tinyalu start/done command interface:
// opcode encodings, the issuer state type and the default operand width.
package tinyalu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Initiator for the tinyalu start/done interface: takes commands on a
// valid/ready port, holds start until done or watchdog expiry, returns result.
module alu_cmd_issuer
  import tinyalu_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned OP_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  output logic                  alu_start,
  output logic [OP_W-1:0]       alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic [OP_W-1:0]       rsp_op,
  output logic                  rsp_err,
  output logic                  spurious_done
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  issuer_state_t        r_state;
  logic [WD_W-1:0]      r_wd;
  logic                 r_alu_start;
  logic [OP_W-1:0]      r_alu_op;
  logic [DATA_W-1:0]    r_alu_a;
  logic [DATA_W-1:0]    r_alu_b;
  logic                 r_rsp_valid;
  logic [2*DATA_W-1:0]  r_rsp_result;
  logic [OP_W-1:0]      r_rsp_op;
  logic                 r_rsp_err;
  logic                 r_spurious;
  logic                 w_is_nop;

  assign w_is_nop = (cmd_op == OP_W'(OP_NOP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_wd         <= '0;
      r_alu_start  <= 1'b0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      if (alu_done && !r_alu_start) begin
        r_spurious <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (w_is_nop) begin
              // NOP never reaches the responder; it completes locally.
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_op     <= '0;
              r_rsp_err    <= 1'b0;
              r_state      <= ST_RESP;
            end else begin
              r_alu_op    <= cmd_op;
              r_alu_a     <= cmd_a;
              r_alu_b     <= cmd_b;
              r_alu_start <= 1'b1;
              r_wd        <= '0;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // done is checked first so it wins over a coincident timeout
          if (alu_done) begin
            r_alu_start  <= 1'b0;
            r_rsp_result <= alu_result;
            r_rsp_op     <= r_alu_op;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_wd == WD_LAST) begin
            r_alu_start  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_op     <= r_alu_op;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (r_state == ST_IDLE);
  assign alu_start     = r_alu_start;
  assign alu_op        = r_alu_op;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_op        = r_rsp_op;
  assign rsp_err       = r_rsp_err;
  assign spurious_done = r_spurious;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed cases plus randomized commands with a
// behavioural responder of configurable latency and a transaction-level model.
module tb_alu_cmd_issuer;
  import tinyalu_pkg::*;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OW-1:0]   cmd_op;
  logic [DW-1:0]   cmd_a;
  logic [DW-1:0]   cmd_b;
  logic            alu_start;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_done;
  logic [2*DW-1:0] alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_result;
  logic [OW-1:0]   rsp_op;
  logic            rsp_err;
  logic            spurious_done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DATA_W(DW), .OP_W(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .spurious_done(spurious_done)
  );

  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {8'h00, a} + {8'h00, b};
      OP_AND:  return {8'h00, a & b};
      OP_XOR:  return {8'h00, a ^ b};
      OP_MUL:  return {8'h00, a} * {8'h00, b};
      default: return 16'hBEEF ^ {a, b};
    endcase
  endfunction

  // Responder: raises done for one cycle 'lat' cycles after it first sees
  // start; lat==0 means it never answers. Result bus carries junk otherwise.
  logic [OW-1:0] cur_op;
  logic [DW-1:0] cur_a, cur_b;
  int unsigned   lat;
  logic          inj_done;
  logic          resp_done;
  logic          resp_fired;
  int unsigned   resp_cnt;
  logic [15:0]   junk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_done  <= 1'b0;
      resp_fired <= 1'b0;
      resp_cnt   <= 0;
    end else if (alu_start && !resp_fired) begin
      resp_cnt <= resp_cnt + 1;
      if (lat != 0 && resp_cnt + 1 == lat) begin
        resp_done  <= 1'b1;
        resp_fired <= 1'b1;
      end else begin
        resp_done <= 1'b0;
      end
    end else begin
      resp_done <= 1'b0;
      if (!alu_start) begin
        resp_fired <= 1'b0;
        resp_cnt   <= 0;
      end
    end
  end

  always @(posedge clk) junk <= 16'($urandom);

  assign alu_done   = resp_done | inj_done;
  assign alu_result = resp_done ? alu_model(cur_op, cur_a, cur_b) : junk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction, entered and left just after a falling edge.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int unsigned lat_i, input int unsigned d);
    bit          nop, tmo, got, bad_hold, bad_ready, bad_stable;
    int unsigned k, starts, exp_k;
    logic [31:0] snap;
    logic [15:0] exp_res;
    nop = (op == OP_NOP);
    tmo = !nop && (lat_i == 0 || lat_i + 1 > TO);
    exp_k = nop ? 0 : (tmo ? TO : lat_i + 1);
    exp_res = (nop || tmo) ? 16'h0 : alu_model(op, a, b);

    check_eq("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cur_op = op; cur_a = a; cur_b = b; lat = lat_i;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    rsp_ready = (d == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);

    got = 0; k = 0; starts = 0; bad_hold = 0; bad_ready = 0;
    for (int i = 0; i < 64; i++) begin
      if (rsp_valid) begin got = 1; break; end
      if (alu_start) begin
        starts++;
        if ({alu_op, alu_a, alu_b} !== {op, a, b}) bad_hold = 1;
      end
      if (cmd_ready) bad_ready = 1;
      k++;
      @(negedge clk);
    end
    check_eq("rsp_seen", {31'b0, got}, 1);
    check_eq("rsp_latency", k, exp_k);
    check_eq("start_cycles", starts, exp_k);
    check_eq("start_low_at_rsp", {31'b0, alu_start}, 0);
    check_eq("ops_held", {31'b0, bad_hold}, 0);
    check_eq("busy_not_ready", {31'b0, bad_ready | cmd_ready}, 0);
    check_eq("rsp_result", {16'b0, rsp_result}, {16'b0, exp_res});
    check_eq("rsp_op", {29'b0, rsp_op}, {29'b0, (nop ? 3'b000 : op)});
    check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, tmo});

    snap = {12'b0, rsp_err, rsp_op, rsp_result};
    bad_stable = 0;
    for (int j = 0; j < int'(d); j++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || {12'b0, rsp_err, rsp_op, rsp_result} !== snap) bad_stable = 1;
    end
    if (d > 0) check_eq("rsp_held_stable", {31'b0, bad_stable}, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_dropped", {31'b0, rsp_valid}, 0);
    check_eq("ready_after_hs", {31'b0, cmd_ready}, 1);
    check_eq("start_low_between", {31'b0, alu_start}, 0);
    if (!nop) check_eq("ops_retained", {13'b0, alu_op, alu_a, alu_b}, {13'b0, op, a, b});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit bad;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; inj_done = 1'b0; lat = 0;
    cur_op = '0; cur_a = '0; cur_b = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check_eq("rst_outputs", {27'b0, alu_start, rsp_valid, rsp_err, spurious_done, 1'b0}, 0);
    check_eq("rst_alu_bus", {13'b0, alu_op, alu_a, alu_b}, 0);
    check_eq("rst_rsp_bus", {13'b0, rsp_op, rsp_result}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_cmd(OP_ADD, 8'hFF, 8'h01, 1, 0);
    run_cmd(OP_XOR, 8'hA5, 8'h0F, 1, 5);
    run_cmd(OP_NOP, 8'h12, 8'h34, 1, 0);
    run_cmd(OP_AND, 8'h55, 8'h33, 0, 0);
    run_cmd(OP_ADD, 8'h03, 8'h04, 1, 0);
    run_cmd(OP_AND, 8'hF0, 8'h3C, 1, 0);
    run_cmd(OP_MUL, 8'hFF, 8'hFF, 15, 1);
    run_cmd(OP_XOR, 8'h0F, 8'hF0, 14, 0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      int unsigned l;
      op = 3'($urandom_range(0, 7));
      l  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      run_cmd(op, 8'($urandom), 8'($urandom), l, $urandom_range(0, 3));
    end

    check_eq("no_spurious_yet", {31'b0, spurious_done}, 0);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check_eq("spurious_set", {31'b0, spurious_done}, 1);
    check_eq("spurious_no_rsp", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    check_eq("spurious_still_idle", {30'b0, rsp_valid, cmd_ready}, 1);

    cur_op = OP_ADD; cur_a = 8'h11; cur_b = 8'h22; lat = 0;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 8'h11; cmd_b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_issue_start", {31'b0, alu_start}, 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_start", {31'b0, alu_start}, 0);
    check_eq("async_rst_valid", {31'b0, rsp_valid}, 0);
    check_eq("async_rst_sticky", {31'b0, spurious_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_start || !cmd_ready) bad = 1;
    end
    check_eq("no_stale_rsp", {31'b0, bad}, 0);
    run_cmd(OP_MUL, 8'h10, 8'h20, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the tinyalu start/done command interface.
- Accepts operations from an upstream valid/ready command port and drives start/op/A/B to an ALU responder.
- Holds the command stable until the responder pulses done, captures the 16-bit result, and returns it on a valid/ready response port.
- Completes NOP locally and recovers from a silent responder with a watchdog timeout.

Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W.
- OP_W, 3, opcode width.
- TIMEOUT_CYCLES, 16, max cycles start may stay high without done before an error response; legal range >= 2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  issuer can accept a command.
- cmd_op  input  OP_W  opcode.
- cmd_a  input  DATA_W  operand A.
- cmd_b  input  DATA_W  operand B.
- alu_start  output  1  start to responder.
- alu_op  output  OP_W  opcode to responder.
- alu_a  output  DATA_W  operand A to responder.
- alu_b  output  DATA_W  operand B to responder.
- alu_done  input  1  completion pulse from responder.
- alu_result  input  2*DATA_W  responder result, valid in the cycle alu_done=1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts response.
- rsp_result  output  2*DATA_W  captured result.
- rsp_op  output  OP_W  opcode of the completed command.
- rsp_err  output  1  1 = timed out; rsp_result is 0.
- spurious_done  output  1  sticky: alu_done seen while alu_start=0; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0): state IDLE; alu_start, rsp_valid, rsp_err, spurious_done = 0; alu_op/alu_a/alu_b/rsp_result/rsp_op = 0; watchdog = 0. A reset during ISSUE or RESP abandons the command with no response.
- States: IDLE, ISSUE, RESP. cmd_ready = (state==IDLE), registered-state decode. There is no combinational path from cmd_valid or rsp_ready to cmd_ready.
- IDLE, accept on cmd_valid&cmd_ready at edge E0:
  - op != NOP: latch op/a/b onto alu_op/alu_a/alu_b, alu_start<=1, watchdog<=0, go to ISSUE.
  - op == NOP (3'b000): no start; rsp_valid<=1, rsp_result<=0, rsp_op<=0, rsp_err<=0, go to RESP.
- ISSUE: alu_start, alu_op, alu_a, alu_b are held constant and the watchdog increments each cycle.
  - alu_done=1 sampled at an edge: alu_start<=0, rsp_result<=alu_result, rsp_op<=alu_op, rsp_err<=0, rsp_valid<=1, go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES-1 without done: alu_start<=0, rsp_result<=0, rsp_err<=1, rsp_valid<=1, go to RESP.
  - Done and timeout at the same edge: done wins, rsp_err=0.
- Latency for a single-cycle op: accept E0, start high after E0, responder done high after E1, start low and rsp_valid high after E2. The responder sees start still high at E2 and drops done on its own; the issuer must not re-raise start.
- RESP: rsp_* held stable while rsp_valid&!rsp_ready. On rsp_ready: rsp_valid<=0, go to IDLE.
  - The next command is accepted no earlier than the cycle after the handshake, so there is at least one idle cycle with start=0 between commands.
- alu_done while alu_start=0 (IDLE or RESP): ignored for data, spurious_done<=1.
- Operand/opcode outputs retain their last value after completion; they are not cleared.
- Watchdog width: $clog2(TIMEOUT_CYCLES+1). It never wraps, because ISSUE exits at the terminal count.

Decomposition:
- Shared package tinyalu_pkg holds:
  - opcode constants: OP_NOP=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_XOR=3'b011, OP_MUL=3'b100;
  - the issuer state enum (IDLE/ISSUE/RESP);
  - DATA_W default.
- No sub-module. The watchdog is a single counter inline in the FSM.

Test Plan:
- ADD a=8'hFF b=8'h01, rsp_ready=1, single-cycle responder -> start high exactly 2 cycles; rsp_valid 2 cycles after accept; rsp_result=16'h0100, rsp_op=001, rsp_err=0.
- XOR a=8'hA5 b=8'h0F, rsp_ready low 5 cycles -> rsp_valid held, rsp_result=16'h00AA stable; cmd_ready=0 throughout; accepted after handshake +1 cycle.
- NOP with any operands -> alu_start never asserts; rsp_valid 1 cycle after accept; rsp_result=0, rsp_err=0.
- AND with responder never asserting done, TIMEOUT_CYCLES=16 -> start high 16 cycles then low; rsp_err=1, rsp_result=0; next command proceeds normally.
- Back-to-back ADD 3+4 then AND 8'hF0&8'h3C -> results 16'h0007 and 16'h0030 in order; start low at least 1 cycle between commands.
- Reset asserted mid-ISSUE -> alu_start, rsp_valid drop immediately (async); after release cmd_ready=1, no stale response. Done injected in IDLE -> spurious_done=1, no rsp_valid.
